// File: rtl/uart_debug_reader_pkg.sv
// ============================================================================
// Module  : uart_debug_reader_pkg
// Purpose : Shared UART debug constants (the "uart_defines" set). Holds the
//           address width, FIFO counter width, the two debug register
//           addresses, the bit positions of every decoded field and the
//           read-engine state encoding.
// Ports   : none (package)
// Macros  : UART_ADDR_WIDTH, UART_FIFO_COUNTER_W (overridable on the
//           command line; default 5 each)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef UART_ADDR_WIDTH
`define UART_ADDR_WIDTH 5
`endif
`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 5
`endif

package uart_debug_reader_pkg;

    localparam int UART_ADDR_W = `UART_ADDR_WIDTH;
    localparam int FIFO_CNT_W  = `UART_FIFO_COUNTER_W;

    // Debug register addresses inside the UART register map
    localparam logic [UART_ADDR_W-1:0] DBG_ADDR_WORD0 = UART_ADDR_W'(5'b01000);
    localparam logic [UART_ADDR_W-1:0] DBG_ADDR_WORD1 = UART_ADDR_W'(5'b01100);

    // Word0 field positions
    localparam int W0_MSR_HI = 31;
    localparam int W0_MSR_LO = 24;
    localparam int W0_LCR_HI = 23;
    localparam int W0_LCR_LO = 16;
    localparam int W0_IIR_HI = 15;
    localparam int W0_IIR_LO = 12;
    localparam int W0_IER_HI = 11;
    localparam int W0_IER_LO = 8;
    localparam int W0_LSR_HI = 7;
    localparam int W0_LSR_LO = 0;

    // Word1 field positions (bits [31:24] carry nothing of interest)
    localparam int W1_FCR_HI = 23;
    localparam int W1_FCR_LO = 22;
    localparam int W1_MCR_HI = 21;
    localparam int W1_MCR_LO = 17;
    localparam int W1_RFC_HI = 16;
    localparam int W1_RFC_LO = 12;
    localparam int W1_RST_HI = 11;
    localparam int W1_RST_LO = 8;
    localparam int W1_TFC_HI = 7;
    localparam int W1_TFC_LO = 3;
    localparam int W1_TST_HI = 2;
    localparam int W1_TST_LO = 0;

    // Read engine states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD0  = 2'd1,
        ST_RD1  = 2'd2,
        ST_HOLD = 2'd3
    } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_wb_rd_master.sv
// ============================================================================
// Module  : uart_wb_rd_master
// Purpose : Wishbone read engine for the debug snapshot. Issues two reads
//           (word0, then word1 after a one-cycle strobe gap), aborts a read
//           that is not acknowledged within TIMEOUT cycles, then holds until
//           the consumer releases the snapshot.
// Ports   : wb_clk_i/wb_rst_i  clock, async active-low reset
//           req_i              start request (acted on only when idle)
//           release_i          consumer accepts the held snapshot
//           wbm_ack_i          slave acknowledge
//           wbm_adr_o/cyc/stb  bus request
//           word0_ack_o        word0 data valid on the bus this cycle
//           word1_ack_o        word1 data valid on the bus this cycle
//           abort_o            read abandoned on timeout this cycle
//           busy_o             engine not idle
//           hold_o             snapshot held (snap_valid)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_wb_rd_master
    import uart_debug_reader_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   req_i,
    input  logic                   release_i,
    input  logic                   wbm_ack_i,
    output logic [UART_ADDR_W-1:0] wbm_adr_o,
    output logic                   wbm_cyc_o,
    output logic                   wbm_stb_o,
    output logic                   word0_ack_o,
    output logic                   word1_ack_o,
    output logic                   abort_o,
    output logic                   busy_o,
    output logic                   hold_o
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    rd_state_e              state_q, state_d;
    logic                   cyc_q, cyc_d;
    logic                   stb_q, stb_d;
    logic [UART_ADDR_W-1:0] adr_q, adr_d;
    logic [7:0]             tmo_q, tmo_d;

    logic ack_hit;
    logic expired;

    // An ack only counts while our strobe is out; this also masks acks
    // during the word0/word1 gap cycle and in IDLE/HOLD.
    assign ack_hit = stb_q && wbm_ack_i;
    assign expired = (tmo_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        adr_d       = adr_q;
        tmo_d       = tmo_q;
        word0_ack_o = 1'b0;
        word1_ack_o = 1'b0;
        abort_o     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d = ST_RD0;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    adr_d   = DBG_ADDR_WORD0;
                    tmo_d   = 8'd0;
                end
            end
            ST_RD0, ST_RD1: begin
                if (ack_hit) begin
                    tmo_d = 8'd0;
                    if (state_q == ST_RD0) begin
                        // Word0 done: keep the cycle, drop strobe for one beat.
                        word0_ack_o = 1'b1;
                        state_d     = ST_RD1;
                        stb_d       = 1'b0;
                        adr_d       = DBG_ADDR_WORD1;
                    end else begin
                        word1_ack_o = 1'b1;
                        state_d     = ST_HOLD;
                        cyc_d       = 1'b0;
                        stb_d       = 1'b0;
                        adr_d       = '0;
                    end
                end else if (expired) begin
                    abort_o = 1'b1;
                    state_d = ST_IDLE;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    adr_d   = '0;
                end else begin
                    // Re-raises strobe after the gap cycle; no-op otherwise.
                    stb_d = 1'b1;
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (release_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                adr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            adr_q   <= '0;
            tmo_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            adr_q   <= adr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign wbm_adr_o = adr_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign hold_o    = (state_q == ST_HOLD);

endmodule

`default_nettype wire

// File: rtl/uart_debug_reader.sv
// ============================================================================
// Module  : uart_debug_reader
// Purpose : Takes a two-word debug snapshot of a UART core over Wishbone and
//           presents the decoded register fields with a valid/ready
//           handshake. Counts dropped requests and flags read timeouts.
// Ports   : wb_clk_i, wb_rst_i (async active-low)
//           wbm_* Wishbone master (read only)
//           trig_i snapshot request; snap_valid_o/snap_ready_i handshake
//           msr/lcr/iir/ier/lsr/fcr/mcr/rf_count/rstate/tf_count/tstate
//           decoded fields; timeout_o sticky; overrun_o saturating count
// Config  : UART_DEBUG_READER_AUTOPOLL_EN - when defined, an internal 16-bit
//           timer requests a snapshot every POLL_PERIOD cycles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_debug_reader
    import uart_debug_reader_pkg::*;
#(
    parameter int TIMEOUT     = 16,
    parameter int POLL_PERIOD = 1000
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    output logic [UART_ADDR_W-1:0] wbm_adr_o,
    output logic                   wbm_cyc_o,
    output logic                   wbm_stb_o,
    output logic                   wbm_we_o,
    output logic [3:0]             wbm_sel_o,
    input  logic [31:0]            wbm_dat_i,
    input  logic                   wbm_ack_i,
    input  logic                   trig_i,
    output logic                   snap_valid_o,
    input  logic                   snap_ready_i,
    output logic [7:0]             msr_o,
    output logic [7:0]             lcr_o,
    output logic [7:0]             lsr_o,
    output logic [3:0]             iir_o,
    output logic [3:0]             ier_o,
    output logic [3:0]             rstate_o,
    output logic [4:0]             mcr_o,
    output logic [1:0]             fcr_o,
    output logic [2:0]             tstate_o,
    output logic [FIFO_CNT_W-1:0]  rf_count_o,
    output logic [FIFO_CNT_W-1:0]  tf_count_o,
    output logic                   timeout_o,
    output logic [7:0]             overrun_o
);

    logic poll_tick;
    logic req;
    logic word0_ack, word1_ack, abort, busy, hold;

    // ------------------------------------------------------------------
    // Optional periodic request source
    // ------------------------------------------------------------------
`ifdef UART_DEBUG_READER_AUTOPOLL_EN
    localparam logic [15:0] POLL_LAST = 16'(POLL_PERIOD - 1);

    logic [15:0] poll_cnt_q, poll_cnt_d;

    assign poll_tick  = (poll_cnt_q == POLL_LAST);
    assign poll_cnt_d = poll_tick ? 16'd0 : poll_cnt_q + 16'd1;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            poll_cnt_q <= 16'd0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
        end
    end
`else
    // No timer in this build; POLL_PERIOD has no effect.
    assign poll_tick = 1'b0;
`endif

    assign req = trig_i | poll_tick;

    // ------------------------------------------------------------------
    // Bus read engine
    // ------------------------------------------------------------------
    uart_wb_rd_master #(
        .TIMEOUT (TIMEOUT)
    ) u_rd_master (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .req_i       (req),
        .release_i   (snap_ready_i),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .word0_ack_o (word0_ack),
        .word1_ack_o (word1_ack),
        .abort_o     (abort),
        .busy_o      (busy),
        .hold_o      (hold)
    );

    assign wbm_we_o     = 1'b0;
    assign wbm_sel_o    = 4'hF;
    assign snap_valid_o = hold;

    // ------------------------------------------------------------------
    // Snapshot buffering and decode. Word0 is staged privately so every
    // visible field updates together on the word1 ack; an aborted read
    // therefore never leaves a half-updated snapshot on the outputs.
    // ------------------------------------------------------------------
    logic [31:0]           word0_q;
    logic [7:0]            msr_q, lcr_q, lsr_q;
    logic [3:0]            iir_q, ier_q, rstate_q;
    logic [4:0]            mcr_q;
    logic [1:0]            fcr_q;
    logic [2:0]            tstate_q;
    logic [FIFO_CNT_W-1:0] rfc_q, tfc_q;
    logic                  timeout_q;
    logic [7:0]            overrun_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            word0_q   <= 32'd0;
            msr_q     <= 8'd0;
            lcr_q     <= 8'd0;
            lsr_q     <= 8'd0;
            iir_q     <= 4'd0;
            ier_q     <= 4'd0;
            rstate_q  <= 4'd0;
            mcr_q     <= 5'd0;
            fcr_q     <= 2'd0;
            tstate_q  <= 3'd0;
            rfc_q     <= '0;
            tfc_q     <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 8'd0;
        end else begin
            if (word0_ack) begin
                word0_q <= wbm_dat_i;
            end
            if (word1_ack) begin
                msr_q    <= word0_q[W0_MSR_HI:W0_MSR_LO];
                lcr_q    <= word0_q[W0_LCR_HI:W0_LCR_LO];
                iir_q    <= word0_q[W0_IIR_HI:W0_IIR_LO];
                ier_q    <= word0_q[W0_IER_HI:W0_IER_LO];
                lsr_q    <= word0_q[W0_LSR_HI:W0_LSR_LO];
                fcr_q    <= wbm_dat_i[W1_FCR_HI:W1_FCR_LO];
                mcr_q    <= wbm_dat_i[W1_MCR_HI:W1_MCR_LO];
                rfc_q    <= FIFO_CNT_W'(wbm_dat_i[W1_RFC_HI:W1_RFC_LO]);
                rstate_q <= wbm_dat_i[W1_RST_HI:W1_RST_LO];
                tfc_q    <= FIFO_CNT_W'(wbm_dat_i[W1_TFC_HI:W1_TFC_LO]);
                tstate_q <= wbm_dat_i[W1_TST_HI:W1_TST_LO];
            end
            if (abort) begin
                timeout_q <= 1'b1;
            end
            // A request that finds the engine busy is lost; count it.
            if (req && busy && (overrun_q != 8'hFF)) begin
                overrun_q <= overrun_q + 8'd1;
            end
        end
    end

    assign msr_o      = msr_q;
    assign lcr_o      = lcr_q;
    assign lsr_o      = lsr_q;
    assign iir_o      = iir_q;
    assign ier_o      = ier_q;
    assign rstate_o   = rstate_q;
    assign mcr_o      = mcr_q;
    assign fcr_o      = fcr_q;
    assign tstate_o   = tstate_q;
    assign rf_count_o = rfc_q;
    assign tf_count_o = tfc_q;
    assign timeout_o  = timeout_q;
    assign overrun_o  = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_debug_reader.sv
// ============================================================================
// Module  : tb_uart_debug_reader
// Purpose : Self-checking bench for uart_debug_reader. A small Wishbone
//           slave model returns two programmable words with a programmable
//           number of wait states; snapshot decodes are compared against a
//           hand-computed vector table, followed by directed sequences for
//           back-pressure/overrun, timeout, saturation and async reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_debug_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  adr;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        ack;
    logic        trig, ready, valid;
    logic [7:0]  msr, lcr, lsr, ovr;
    logic [3:0]  iir, ier, rstate;
    logic [4:0]  mcr, rfc, tfc;
    logic [1:0]  fcr;
    logic [2:0]  tstate;
    logic        tmo;

    always #5 clk = ~clk;

    uart_debug_reader #(
        .TIMEOUT     (16),
        .POLL_PERIOD (50)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst_n),
        .wbm_adr_o    (adr),
        .wbm_cyc_o    (cyc),
        .wbm_stb_o    (stb),
        .wbm_we_o     (we),
        .wbm_sel_o    (sel),
        .wbm_dat_i    (dat),
        .wbm_ack_i    (ack),
        .trig_i       (trig),
        .snap_valid_o (valid),
        .snap_ready_i (ready),
        .msr_o        (msr),
        .lcr_o        (lcr),
        .lsr_o        (lsr),
        .iir_o        (iir),
        .ier_o        (ier),
        .rstate_o     (rstate),
        .mcr_o        (mcr),
        .fcr_o        (fcr),
        .tstate_o     (tstate),
        .rf_count_o   (rfc),
        .tf_count_o   (tfc),
        .timeout_o    (tmo),
        .overrun_o    (ovr)
    );

    // ---------------- Wishbone slave model ----------------
    logic [31:0] w0, w1;
    int          wait_st;
    int          wcnt;
    logic        en0, en1, force_ack;

    always @(posedge clk) wcnt <= (cyc && stb) ? wcnt + 1 : 0;

    assign ack = force_ack |
                 (cyc && stb && (wcnt == wait_st) && ((adr == 5'b01000) ? en0 : en1));
    assign dat = (adr == 5'b01000) ? w0 : w1;

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        step(1);
        trig = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (valid) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        chk({name, "_valid_seen"}, 32'(ok), 32'd1);
    endtask

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        int          wt;
        logic [7:0]  msr, lcr, lsr;
        logic [3:0]  iir, ier, rstate;
        logic [4:0]  mcr, rfc, tfc;
        logic [1:0]  fcr;
        logic [2:0]  tstate;
    } vec_t;

    vec_t vecs[4];

    task automatic check_fields(input string tag, input vec_t v);
        chk({tag, "_msr"},    32'(msr),    32'(v.msr));
        chk({tag, "_lcr"},    32'(lcr),    32'(v.lcr));
        chk({tag, "_iir"},    32'(iir),    32'(v.iir));
        chk({tag, "_ier"},    32'(ier),    32'(v.ier));
        chk({tag, "_lsr"},    32'(lsr),    32'(v.lsr));
        chk({tag, "_fcr"},    32'(fcr),    32'(v.fcr));
        chk({tag, "_mcr"},    32'(mcr),    32'(v.mcr));
        chk({tag, "_rfc"},    32'(rfc),    32'(v.rfc));
        chk({tag, "_rstate"}, 32'(rstate), 32'(v.rstate));
        chk({tag, "_tfc"},    32'(tfc),    32'(v.tfc));
        chk({tag, "_tstate"}, 32'(tstate), 32'(v.tstate));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cyc"},   32'(cyc),   32'd0);
        chk({tag, "_stb"},   32'(stb),   32'd0);
        chk({tag, "_adr"},   32'(adr),   32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_tmo"},   32'(tmo),   32'd0);
        chk({tag, "_ovr"},   32'(ovr),   32'd0);
        chk({tag, "_msr"},   32'(msr),   32'd0);
        chk({tag, "_lsr"},   32'(lsr),   32'd0);
        chk({tag, "_mcr"},   32'(mcr),   32'd0);
        chk({tag, "_tstate"},32'(tstate),32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          w0            w1            wt  msr    lcr    lsr    iir   ier   rst   mcr    rfc    tfc    fcr   tst
        vecs[0] = '{32'hA1B2_C3D4, 32'h00FF_FFFF, 1, 8'hA1, 8'hB2, 8'hD4, 4'hC, 4'h3, 4'hF, 5'h1F, 5'h1F, 5'h1F, 2'd3, 3'd7};
        vecs[1] = '{32'h1234_5678, 32'hFF00_0000, 0, 8'h12, 8'h34, 8'h78, 4'h5, 4'h6, 4'h0, 5'h00, 5'h00, 5'h00, 2'd0, 3'd0};
        vecs[2] = '{32'hFEDC_BA98, 32'h00A5_5A5A, 3, 8'hFE, 8'hDC, 8'h98, 4'hB, 4'hA, 4'hA, 5'h12, 5'h15, 5'h0B, 2'd2, 3'd2};
        vecs[3] = '{32'h8001_7FFF, 32'h1240_0000, 2, 8'h80, 8'h01, 8'hFF, 4'h7, 4'hF, 4'h0, 5'h00, 5'h00, 5'h00, 2'd1, 3'd0};

        rst_n = 1'b0; trig = 1'b0; ready = 1'b0;
        w0 = 32'd0; w1 = 32'd0; wait_st = 0;
        en0 = 1'b1; en1 = 1'b1; force_ack = 1'b0;
        step(3);
        check_all_zero("reset");
        chk("reset_we",  32'(we),  32'd0);
        chk("reset_sel", 32'(sel), 32'hF);
        rst_n = 1'b1;
        step(1);

`ifdef UART_DEBUG_READER_AUTOPOLL_EN
        // Periodic snapshots with an always-ready consumer
        begin
            int rise_t[$];
            int t;
            logic prev_v;
            ready = 1'b1; wait_st = 0;
            w0 = vecs[0].w0; w1 = vecs[0].w1;
            t = 0; prev_v = 1'b0;
            for (int i = 0; i < 400 && rise_t.size() < 5; i++) begin
                if (valid && !prev_v) rise_t.push_back(t);
                prev_v = valid;
                step(1);
                t++;
            end
            chk("poll_snap_count", 32'(rise_t.size()), 32'd5);
            for (int k = 1; k < rise_t.size(); k++)
                chk("poll_spacing", 32'(rise_t[k] - rise_t[k-1]), 32'd50);
            chk("poll_ovr", 32'(ovr), 32'd0);
            check_fields("poll", vecs[0]);
        end
`else
        // Acks while idle are ignored
        force_ack = 1'b1;
        step(3);
        force_ack = 1'b0;
        chk("idle_ack_cyc",   32'(cyc),   32'd0);
        chk("idle_ack_valid", 32'(valid), 32'd0);

        // Table-driven snapshots
        for (int v = 0; v < 4; v++) begin
            w0 = vecs[v].w0; w1 = vecs[v].w1; wait_st = vecs[v].wt;
            pulse_trig();
            wait_valid($sformatf("vec%0d", v));
            check_fields($sformatf("vec%0d", v), vecs[v]);
            chk($sformatf("vec%0d_cyc_hold", v), 32'(cyc), 32'd0);
            ready = 1'b1;
            step(1);
            ready = 1'b0;
            chk($sformatf("vec%0d_valid_drop", v), 32'(valid), 32'd0);
            chk($sformatf("vec%0d_ovr", v), 32'(ovr), 32'd0);
        end

        // Back-pressure: valid held, three dropped requests
        w0 = vecs[0].w0; w1 = vecs[0].w1; wait_st = 1;
        pulse_trig();
        wait_valid("hold");
        for (int i = 0; i < 10; i++) begin
            trig = (i == 2 || i == 5 || i == 8);
            step(1);
        end
        trig = 1'b0;
        chk("hold_valid", 32'(valid), 32'd1);
        chk("hold_ovr",   32'(ovr),   32'd3);
        check_fields("hold", vecs[0]);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        chk("hold_valid_drop", 32'(valid), 32'd0);

        // Timeout on word1: fields from the previous snapshot must survive
        w0 = 32'h5555_5555; w1 = 32'h00AA_AAAA; en1 = 1'b0;
        pulse_trig();
        begin
            int n;
            for (int i = 0; i < 50; i++) begin
                if (cyc && adr == 5'b01100) break;
                step(1);
            end
            chk("tmo_rd1_entered", 32'(cyc && adr == 5'b01100), 32'd1);
            n = 0;
            for (int i = 0; i < 100; i++) begin
                if (!cyc) break;
                n++;
                step(1);
            end
            chk("tmo_cycles", 32'(n), 32'd16);
        end
        chk("tmo_flag", 32'(tmo), 32'd1);
        step(3);
        chk("tmo_no_valid", 32'(valid), 32'd0);
        chk("tmo_ovr",      32'(ovr),   32'd3);
        check_fields("tmo_kept", vecs[0]);
        en1 = 1'b1;

        // Saturation of the overrun counter
        w0 = vecs[1].w0; w1 = vecs[1].w1; wait_st = 0;
        pulse_trig();
        wait_valid("sat");
        trig = 1'b1;
        step(300);
        trig = 1'b0;
        chk("sat_ovr",   32'(ovr),   32'd255);
        chk("sat_tmo",   32'(tmo),   32'd1);
        check_fields("sat", vecs[1]);
        ready = 1'b1;
        step(1);
        ready = 1'b0;

        // Reset in the middle of a word0 read
        en0 = 1'b0;
        pulse_trig();
        chk("rst_rd0_stb", 32'(stb), 32'd1);
        chk("rst_rd0_adr", 32'(adr), 32'h08);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        step(2);
        rst_n = 1'b1;
        en0 = 1'b1;
        step(2);
        chk("post_rst_cyc", 32'(cyc), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_debug_reader.md
UART_DEBUG_READER -- requirements
Module: uart_debug_reader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: wishbone cycles to wait for ack before aborting a read (range 2..255).
REQ-002 SHALL have parameter POLL_PERIOD, default 1000: clock cycles between automatic snapshots (autopoll build only, range 1..65535).
REQ-003 SHALL have ports, one per line: name direction width meaning:
- wb_clk_i  in  1  sole clock, rising edge
- wb_rst_i  in  1  asynchronous, active-low reset
- wbm_adr_o  out  `UART_ADDR_WIDTH  debug register address
- wbm_cyc_o / wbm_stb_o  out  1  Wishbone cycle / strobe
- wbm_we_o  out  1  constant 0
- wbm_sel_o  out  4  constant 4'hF
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  read acknowledge
- trig_i  in  1  one-cycle snapshot request
- snap_valid_o  out  1  snapshot available
- snap_ready_i  in  1  consumer accepts snapshot
- msr_o, lcr_o, lsr_o  out  8 each  decoded fields
- iir_o, ier_o, rstate_o  out  4 each  decoded fields
- mcr_o  out  5;  fcr_o  out  2;  tstate_o  out  3
- rf_count_o, tf_count_o  out  `UART_FIFO_COUNTER_W each  FIFO levels
- timeout_o  out  1  sticky: a read aborted on timeout
- overrun_o  out  8  saturating count of dropped requests

Function
REQ-004 SHALL implement FSM IDLE -> RD0 -> RD1 -> HOLD -> IDLE.
REQ-005 IDLE: on request (trig_i, or autopoll tick), go to RD0 next cycle with cyc/stb=1, adr=5'b01000.
REQ-006 RD0: on wbm_ack_i, register wbm_dat_i as word0, deassert stb for exactly one cycle, then RD1 with adr=5'b01100.
REQ-007 RD1: on wbm_ack_i, register word1, drop cyc/stb, go to HOLD, and assert snap_valid_o the following cycle.
REQ-008 Word0 decode: msr=[31:24], lcr=[23:16], iir=[15:12], ier=[11:8], lsr=[7:0].
REQ-009 Word1 decode: fcr=[23:22], mcr=[21:17], rf_count=[16:12], rstate=[11:8], tf_count=[7:3], tstate=[2:0]; bits [31:24] ignored.
REQ-010 Decoded outputs SHALL change only on the RD1 ack, so word0 and word1 fields always come from the same snapshot.
REQ-011 HOLD: snap_valid_o=1; on snap_valid_o&&snap_ready_i, clear valid, go to IDLE; ready without valid is ignored.
REQ-012 A request arriving in any state other than IDLE SHALL be dropped and SHALL increment overrun_o, saturating at 255.
REQ-013 Timeout counter reloads on entering RD0/RD1; if no ack within TIMEOUT cycles: drop cyc/stb, set timeout_o, go to IDLE; no snapshot is produced and decoded outputs keep their values.
REQ-014 An ack in IDLE or HOLD SHALL be ignored.
REQ-015 timeout_o and overrun_o SHALL clear only on reset.

Reset
REQ-016 Assertion of wb_rst_i (low) SHALL immediately force: FSM=IDLE, cyc/stb=0, adr=0, snap_valid_o=0, all decoded outputs=0, timeout_o=0, overrun_o=0, poll timer=0.
REQ-017 Reset asserted mid-cycle SHALL abandon the bus cycle without waiting for ack.

Configuration
REQ-018 Macro UART_DEBUG_READER_AUTOPOLL_EN: when defined, a 16-bit timer issues an internal request every POLL_PERIOD cycles; trig_i still works; a tick lost to busy state counts as overrun.
REQ-019 Without UART_DEBUG_READER_AUTOPOLL_EN, no timer SHALL exist; only trig_i starts reads, and POLL_PERIOD is unused.

Structure
REQ-020 The debug addresses (5'b01000, 5'b01100), field bit positions and FSM state encodings SHALL be constants in the shared uart_defines include, alongside UART_ADDR_WIDTH and UART_FIFO_COUNTER_W.
REQ-021 The Wishbone read engine (strobe, ack, timeout) SHALL be one sub-module, uart_wb_rd_master; decode and buffering stay in the top level.

Verification
REQ-022 Directed scenarios:
- trig_i pulse; slave acks word0=32'hA1B2_C3D4, word1=32'h00FF_FFFF after 1 wait state -> msr=A1, lcr=B2, iir=C, ier=3, lsr=D4, fcr=3, mcr=1F, tstate=7; snap_valid_o=1.
- Valid held with snap_ready_i=0 for 10 cycles; 3 trig_i pulses -> outputs stable, overrun_o=3; ready=1 -> valid drops next cycle.
- Slave never acks RD1, TIMEOUT=16 -> cyc drops 16 cycles after RD1 entry, timeout_o=1, no valid, previous fields kept.
- wb_rst_i low while in RD0 with stb=1 -> cyc/stb=0 immediately, all outputs 0.
- AUTOPOLL_EN, POLL_PERIOD=50, consumer always ready, zero-wait slave -> exactly one snapshot per 50 cycles, overrun_o=0.
- 300 drops -> overrun_o saturates at 255.
